ysyx_22040931_fetch_buf: RTL
============================

# ysyx_22040931_fetch_buf

Fetch buffer between the PC/IF stage and decode. It turns each PC accepted from the IF stage into an instruction-memory request and tracks responses in order. Completed {pc, inst} pairs are presented to ID through a valid/ready handshake. Responses belonging to a redirected stream are dropped on flush, and IF is stalled when capacity is exhausted.

## Interface
Parameters:
- PC_W, 64, PC / address width
- INST_W, 32, instruction width
- DEPTH, 4, entry count (power of two, ≥2); bounds outstanding + buffered fetches

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 resets state on the clock edge)
- fetch_enb  in  1  IF has a valid PC this cycle
- if_pc  in  PC_W  PC to fetch
- fetch_stall  out  1  IF must hold its PC this cycle (combinational)
- flush  in  1  redirect: discard all buffered and in-flight fetches
- imem_req_valid  out  1  request valid
- imem_req_addr  out  PC_W  request address (= if_pc)
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  response valid; responses in request order, ≥1 cycle after acceptance
- imem_resp_data  in  INST_W  instruction word
- id_valid  out  1  head entry complete
- id_pc  out  PC_W  head PC
- id_inst  out  INST_W  head instruction
- id_ready  in  1  ID consumes head

## Operation
- Entry fields: pc, inst, filled. Pointers: head (pop), fill (next entry to fill), tail (alloc). Counters: count (0..DEPTH), drop_cnt (0..DEPTH).
- space = (count + drop_cnt < DEPTH) or (id_valid & id_ready & drop_cnt + count == DEPTH). Pop and alloc are allowed in the same cycle when full.
- imem_req_valid = fetch_enb & space & ~flush & reset; imem_req_addr = if_pc.
- Alloc on imem_req_valid & imem_req_ready: entry[tail] ← {if_pc, filled=0}; tail++; count++.
- fetch_stall = fetch_enb & ~(imem_req_valid & imem_req_ready) & ~flush. On flush, IF loads the redirect target instead.
- Response: if drop_cnt>0, drop_cnt--, data discarded. Otherwise entry[fill] ← {inst=data, filled=1}; fill++.
- id_valid = entry[head].filled & count>0. id_pc/id_inst come from entry[head]. Pop on id_valid & id_ready: head++, count--.
- Flush: drop_cnt ← (number of unfilled entries) − (1 if imem_resp_valid & drop_cnt==0 this cycle) + drop_cnt − (1 if resp consumed a drop this cycle). The net effect is that every in-flight response is dropped, including one arriving in the flush cycle. Also head=fill=tail ← 0 and count ← 0.
- Flush has priority over pop and alloc in the same cycle. id_ready is ignored when flush=1.
- A response with count==0 and drop_cnt==0 is a protocol error. The assertion fires; state is unchanged.
- Pointer arithmetic is modulo DEPTH (log2(DEPTH) bits). Wrap-around is natural.

## Timing
- Reset values: id_valid=0, id_pc=0, id_inst=0, imem_req_valid=0, imem_req_addr=if_pc (don't-care), fetch_stall=0, count=drop_cnt=0, all pointers 0, all filled=0.
- Request accepted at cycle T, response at T+k (k≥1), id_valid at T+k+1. No response→ID bypass.
- With k=1 and id_ready held high, DEPTH=4 sustains one instruction per cycle.
- Reset mid-operation clears drop_cnt. Memory is reset concurrently, so no stale responses are expected.

## Structure
- Shared defines (defines.v): ysyx_22040931_PC_BUS, ysyx_22040931_INST_BUS widths, FETCH_BUF_DEPTH.
- One sub-module: ysyx_22040931_fetch_ptr (pointer/counter bookkeeping: head/fill/tail, count, drop_cnt, space). The entry array and datapath stay in the top.

## Test plan
- Streaming: fetch_enb=1, PCs 0x80000000, +4, +8…, k=1, id_ready=1 → id_pc sequence 0x80000000, 0x80000004… one per cycle from cycle 3, fetch_stall never 1.
- Backpressure: id_ready=0 → after 4 accepts, fetch_stall=1 and imem_req_valid=0. id_ready=1 for one cycle → exactly one new request accepted the same cycle.
- Variable latency: imem_req_ready toggling, k=1..5 random → id_pc/id_inst pairs match memory model in order, no loss or duplication.
- Flush with 3 in flight: flush at T. The next 3 responses (data 0xDEADBEEF) are dropped. The next ID output is the first post-flush PC 0x80001000, with no id_valid for old PCs after T.
- Flush in same cycle as response and id pop → response dropped, entry not popped twice, id_valid=0 at T+1.
- Reset (reset=0) mid-stream with count=3 → next cycle id_valid=0 and fetch_stall=0. After release, fetching resumes from the new if_pc.

Source files
------------

// File: rtl/ysyx_22040931_fetch_buf_pkg.sv
// Shared widths, depth and response classification for the fetch buffer slice.
package ysyx_22040931_fetch_buf_pkg;

  localparam int unsigned PC_BUS          = 64;
  localparam int unsigned INST_BUS        = 32;
  localparam int unsigned FETCH_BUF_DEPTH = 4;

  // How an incoming imem response is consumed this cycle.
  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_FILL,
    RESP_DROP,
    RESP_ERR
  } resp_kind_e;

endpackage

// File: rtl/ysyx_22040931_fetch_ptr.sv
// Pointer/counter bookkeeping for the fetch buffer: head/fill/tail, occupancy,
// pending fills, responses still to be dropped after a redirect, and space.
module ysyx_22040931_fetch_ptr
  import ysyx_22040931_fetch_buf_pkg::*;
#(
  parameter  int unsigned DEPTH = FETCH_BUF_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_alloc,
  input  logic          i_pop,
  input  logic          i_resp_valid,
  output logic [AW-1:0] o_head,
  output logic [AW-1:0] o_fill,
  output logic [AW-1:0] o_tail,
  output logic [CW-1:0] o_count,
  output logic          o_space,
  output logic          o_fill_en
);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_fill;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_pend;
  logic [CW-1:0] r_drop;

  logic [CW:0]   w_occ;
  logic [CW:0]   w_flush_drop;
  resp_kind_e    w_kind;

  assign w_occ   = {1'b0, r_count} + {1'b0, r_drop};
  assign o_space = (w_occ < (CW+1)'(DEPTH)) | (i_pop & (w_occ == (CW+1)'(DEPTH)));

  // Outstanding drops are served first; a fill needs an allocated, unfilled entry.
  always_comb begin
    w_kind = RESP_NONE;
    if (i_resp_valid) begin
      if (r_drop != '0)      w_kind = RESP_DROP;
      else if (r_pend != '0) w_kind = RESP_FILL;
      else                   w_kind = RESP_ERR;
    end
  end

  assign o_fill_en = (w_kind == RESP_FILL) & ~i_flush;

  // Every response still in flight after a redirect must be discarded,
  // minus the one (if any) that arrives during the redirect cycle itself.
  assign w_flush_drop = {1'b0, r_drop} + {1'b0, r_pend}
                      - (CW+1)'((w_kind == RESP_DROP) || (w_kind == RESP_FILL));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head  <= '0;
      r_fill  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pend  <= '0;
      r_drop  <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_fill  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pend  <= '0;
      r_drop  <= w_flush_drop[CW-1:0];
    end else begin
      r_head  <= r_head + AW'(i_pop);
      r_tail  <= r_tail + AW'(i_alloc);
      r_fill  <= r_fill + AW'(o_fill_en);
      r_count <= r_count + CW'(i_alloc) - CW'(i_pop);
      r_pend  <= r_pend + CW'(i_alloc) - CW'(o_fill_en);
      r_drop  <= r_drop - CW'(w_kind == RESP_DROP);
    end
  end

  assign o_head  = r_head;
  assign o_fill  = r_fill;
  assign o_tail  = r_tail;
  assign o_count = r_count;

  a_resp_expected: assert property (@(posedge clock) disable iff (!reset)
    i_resp_valid |-> ((r_count != '0) || (r_drop != '0)));

endmodule

// File: rtl/ysyx_22040931_fetch_buf.sv
// Fetch buffer: turns IF PCs into in-order imem requests, collects responses
// into an entry ring and hands {pc, inst} to ID over a valid/ready handshake.
module ysyx_22040931_fetch_buf
  import ysyx_22040931_fetch_buf_pkg::*;
#(
  parameter  int unsigned PC_W   = PC_BUS,
  parameter  int unsigned INST_W = INST_BUS,
  parameter  int unsigned DEPTH  = FETCH_BUF_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = AW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_enb,
  input  logic [PC_W-1:0]   if_pc,
  output logic              fetch_stall,
  input  logic              flush,
  output logic              imem_req_valid,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready
);

  logic [PC_W-1:0]   r_pc     [DEPTH];
  logic [INST_W-1:0] r_inst   [DEPTH];
  logic [DEPTH-1:0]  r_filled;

  logic [AW-1:0] w_head;
  logic [AW-1:0] w_fill;
  logic [AW-1:0] w_tail;
  logic [CW-1:0] w_count;
  logic          w_space;
  logic          w_fill_en;
  logic          w_alloc;
  logic          w_pop;

  ysyx_22040931_fetch_ptr #(
    .DEPTH(DEPTH)
  ) u_ptr (
    .clock       (clock),
    .reset       (reset),
    .i_flush     (flush),
    .i_alloc     (w_alloc),
    .i_pop       (w_pop),
    .i_resp_valid(imem_resp_valid),
    .o_head      (w_head),
    .o_fill      (w_fill),
    .o_tail      (w_tail),
    .o_count     (w_count),
    .o_space     (w_space),
    .o_fill_en   (w_fill_en)
  );

  assign imem_req_valid = fetch_enb & w_space & ~flush & reset;
  assign imem_req_addr  = if_pc;
  assign w_alloc        = imem_req_valid & imem_req_ready;
  assign fetch_stall    = fetch_enb & reset & ~w_alloc & ~flush;

  assign id_valid = r_filled[w_head] & (w_count != '0);
  assign id_pc    = r_pc[w_head];
  assign id_inst  = r_inst[w_head];
  assign w_pop    = id_valid & id_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
      end
      r_filled <= '0;
    end else if (flush) begin
      r_filled <= '0;
    end else begin
      if (w_alloc) begin
        r_pc[w_tail]     <= if_pc;
        r_filled[w_tail] <= 1'b0;
      end
      if (w_fill_en) begin
        r_inst[w_fill]   <= imem_resp_data;
        r_filled[w_fill] <= 1'b1;
      end
    end
  end

endmodule
